// File: rtl/regfile_pkg.sv
// regfile_pkg: dump FSM state encodings and default widths for register_file_param.
package regfile_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 3;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_t;
endpackage

// File: rtl/register_file_param_if.sv
// register_file_param_if: write, read and dump port bundle of the register file.
interface register_file_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [ADDR_WIDTH-1:0] read_address_2;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  dump_start;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [ADDR_WIDTH-1:0] dump_index;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_done;
    logic                  busy;
    modport master (
        output write, write_address, write_data, read_address_1, read_address_2,
               dump_start, dump_ready,
        input  read_data_1, read_data_2, dump_valid, dump_index, dump_data, dump_done, busy
    );
    modport slave (
        input  write, write_address, write_data, read_address_1, read_address_2,
               dump_start, dump_ready,
        output read_data_1, read_data_2, dump_valid, dump_index, dump_data, dump_done, busy
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: dump FSM and index counter; tells the top which entry to load and when.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  ready,
    output logic                  valid,
    output logic                  done,
    output logic                  busy,
    output logic                  load,
    output logic [ADDR_WIDTH-1:0] index,
    output logic [ADDR_WIDTH-1:0] load_index
);
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    dump_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] index_next;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end
    // Exiting STREAM at LAST keeps the counter from ever wrapping.
    always_comb begin
        state_next = state;
        index_next = index;
        load       = 1'b0;
        load_index = index + ADDR_WIDTH'(1);
        case (state)
            IDLE: if (start) begin
                state_next = STREAM;
                index_next = '0;
                load       = 1'b1;
                load_index = '0;
            end
            STREAM: if (ready) begin
                if (index == LAST) state_next = DONE;
                else begin
                    index_next = index + ADDR_WIDTH'(1);
                    load       = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    assign valid = state == STREAM;
    assign done  = state == DONE;
    assign busy  = state != IDLE;
endmodule

// File: rtl/register_file_param.sv
// register_file_param: parametrised 2-read/1-write register file with optional zero
// register, write bypass and a handshaked dump port.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input logic                  clk,
    input logic                  reset,
    register_file_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] entry [DEPTH];
    logic                  wr_en, load;
    logic [ADDR_WIDTH-1:0] load_index;
    assign wr_en = bus.write && !(ZERO_REG != 0 && bus.write_address == '0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else if (wr_en) begin
            entry[bus.write_address] <= bus.write_data;
        end
    end
    // Zero register wins over bypass; bypass only when the write is actually taken.
    assign bus.read_data_1 = (ZERO_REG != 0 && bus.read_address_1 == '0) ? '0 :
                             (BYPASS != 0 && wr_en && bus.read_address_1 == bus.write_address) ?
                             bus.write_data : entry[bus.read_address_1];
    assign bus.read_data_2 = (ZERO_REG != 0 && bus.read_address_2 == '0) ? '0 :
                             (BYPASS != 0 && wr_en && bus.read_address_2 == bus.write_address) ?
                             bus.write_data : entry[bus.read_address_2];
    regfile_dump_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (bus.dump_start),
        .ready      (bus.dump_ready),
        .valid      (bus.dump_valid),
        .done       (bus.dump_done),
        .busy       (bus.busy),
        .load       (load),
        .index      (bus.dump_index),
        .load_index (load_index)
    );
    // Beats capture the stored (pre-edge) value, so a same-cycle write is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.dump_data <= '0;
        else if (load) bus.dump_data <= entry[load_index];
    end
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: directed checks on three configurations sharing one stimulus:
// [0] ZERO_REG=0/BYPASS=1, [1] ZERO_REG=1/BYPASS=1, [2] ZERO_REG=0/BYPASS=0.
module tb_register_file_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [2:0]  write_address = '0;
    logic [15:0] write_data = '0;
    logic [2:0]  read_address_1 = '0;
    logic [2:0]  read_address_2 = '0;
    logic        dump_start = 1'b0;
    logic        dump_ready = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    register_file_param_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : cfg
        assign bus[g].write          = write;
        assign bus[g].write_address  = write_address;
        assign bus[g].write_data     = write_data;
        assign bus[g].read_address_1 = read_address_1;
        assign bus[g].read_address_2 = read_address_2;
        assign bus[g].dump_start     = dump_start;
        assign bus[g].dump_ready     = dump_ready;
        register_file_param #(
            .DATA_WIDTH (16),
            .ADDR_WIDTH (3),
            .ZERO_REG   (g == 1 ? 1 : 0),
            .BYPASS     (g == 2 ? 0 : 1)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        write = 1'b1;
        write_address = a;
        write_data = d;
        tick();
        write = 1'b0;
    endtask

    task automatic beat(input int k, input logic [15:0] exp0, input logic [15:0] exp1);
        chk($sformatf("valid%0d", k), bus[0].dump_valid, 1);
        chk($sformatf("index%0d", k), bus[0].dump_index, k);
        chk($sformatf("data%0d", k), bus[0].dump_data, exp0);
        chk($sformatf("zdata%0d", k), bus[1].dump_data, exp1);
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("rst_valid", bus[0].dump_valid, 0);
        chk("rst_index", bus[0].dump_index, 0);
        chk("rst_data", bus[0].dump_data, 0);
        chk("rst_done", bus[0].dump_done, 0);
        chk("rst_busy", bus[0].busy, 0);
        rst = 1'b0;
        tick();

        wr(3'd5, 16'hBEEF);
        read_address_1 = 3'd5;
        read_address_2 = 3'd5;
        #1;
        chk("r5_p1", bus[0].read_data_1, 16'hBEEF);
        chk("r5_p2", bus[0].read_data_2, 16'hBEEF);
        chk("r5_nobyp", bus[2].read_data_2, 16'hBEEF);

        read_address_1 = 3'd2;
        write = 1'b1;
        write_address = 3'd2;
        write_data = 16'h1234;
        #1;
        chk("byp_on", bus[0].read_data_1, 16'h1234);
        chk("byp_off", bus[2].read_data_1, 16'h0000);
        tick();
        write = 1'b0;
        #1;
        chk("byp_off_after", bus[2].read_data_1, 16'h1234);

        read_address_1 = 3'd0;
        write = 1'b1;
        write_address = 3'd0;
        write_data = 16'hFFFF;
        #1;
        chk("zero_byp", bus[1].read_data_1, 16'h0000);
        chk("r0_byp", bus[0].read_data_1, 16'hFFFF);
        tick();
        write = 1'b0;
        #1;
        chk("zero_rd", bus[1].read_data_1, 16'h0000);
        chk("r0_rd", bus[0].read_data_1, 16'hFFFF);

        for (int n = 0; n < 8; n++) wr(3'(n), 16'hA0 + 16'(n));
        start_dump();
        for (int k = 0; k < 8; k++) begin
            beat(k, 16'hA0 + 16'(k), k == 0 ? 16'h0 : 16'hA0 + 16'(k));
            tick();
        end
        chk("done_valid", bus[0].dump_valid, 0);
        chk("done_pulse", bus[0].dump_done, 1);
        chk("done_busy", bus[0].busy, 1);
        tick();
        chk("done_clear", bus[0].dump_done, 0);
        chk("idle_busy", bus[0].busy, 0);

        start_dump();
        for (int k = 0; k < 4; k++) begin
            beat(k, 16'hA0 + 16'(k), k == 0 ? 16'h0 : 16'hA0 + 16'(k));
            tick();
        end
        dump_ready = 1'b0;
        read_address_1 = 3'd4;
        dump_start = 1'b1;
        wr(3'd4, 16'h5555);
        dump_start = 1'b0;
        #1;
        chk("stall_rd_r4", bus[0].read_data_1, 16'h5555);
        for (int s = 0; s < 2; s++) begin
            beat(4, 16'hA4, 16'hA4);
            tick();
        end
        beat(4, 16'hA4, 16'hA4);
        dump_ready = 1'b1;
        write = 1'b1;
        write_address = 3'd5;
        write_data = 16'h7777;
        tick();
        write = 1'b0;
        #1;
        beat(5, 16'hA5, 16'hA5);
        tick();
        beat(6, 16'hA6, 16'hA6);
        tick();
        beat(7, 16'hA7, 16'hA7);
        tick();
        chk("bp_done", bus[0].dump_done, 1);
        tick();

        start_dump();
        for (int k = 0; k < 3; k++) tick();
        beat(3, 16'hA3, 16'hA3);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus[0].dump_valid, 0);
        chk("mid_rst_index", bus[0].dump_index, 0);
        chk("mid_rst_data", bus[0].dump_data, 0);
        chk("mid_rst_busy", bus[0].busy, 0);
        chk("mid_rst_r5", bus[0].read_data_2, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_no_done", bus[0].dump_done, 0);
        start_dump();
        for (int k = 0; k < 8; k++) begin
            beat(k, 16'h0, 16'h0);
            tick();
        end
        chk("post_rst_done", bus[0].dump_done, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
